// File: rtl/cosim_msg_serializer.sv
// cosim_msg_serializer
// Splits one DATA_WIDTH-bit message from the cosim endpoint into
// ceil(DATA_WIDTH/CHUNK_WIDTH) chunks, emitted LSB-first over a
// valid/ready stream. The final chunk is flagged with out_last.
// A new message may be taken in the same cycle the last chunk is accepted,
// so back-to-back messages stream without a bubble.
// msg_count tracks fully emitted messages and wraps at 16 bits.
module cosim_msg_serializer #(
    parameter int DATA_WIDTH  = 24,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CHUNK_WIDTH-1:0] out_data,
    output logic                   out_last,
    output logic [15:0]            msg_count
);

    localparam int NUM_CHUNKS = (CHUNK_WIDTH > 0) ? ((DATA_WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH) : 1;
    localparam int PAD_W      = NUM_CHUNKS * CHUNK_WIDTH;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    // Degenerate widths make no sense for a serializer; stop elaboration.
    if (DATA_WIDTH < 1 || CHUNK_WIDTH < 1) begin : g_bad_params
        $error("cosim_msg_serializer: DATA_WIDTH and CHUNK_WIDTH must both be >= 1");
    end

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;
    logic [IDX_W-1:0]  idx_r;
    logic [PAD_W-1:0]  msg_r;          // captured message, zero-padded to whole chunks
    logic [15:0]       msg_count_r;
    logic              load_s;         // capture in_data this cycle
    logic              adv_s;          // step to the next chunk
    logic              done_s;         // last chunk handed off this cycle
    logic              last_s;

    // Next-state decode, handshake control and stream outputs.
    always_comb begin
        state_nx_s = state_r;
        load_s     = 1'b0;
        adv_s      = 1'b0;
        done_s     = 1'b0;
        last_s     = (idx_r == LAST_IDX);
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_data   = '0;
        in_ready   = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready = rstn;
                if (in_valid) begin
                    load_s     = 1'b1;
                    state_nx_s = SEND;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                out_last  = last_s;
                out_data  = msg_r[int'(idx_r) * CHUNK_WIDTH +: CHUNK_WIDTH];
                in_ready  = rstn && out_ready && last_s;
                if (out_ready) begin
                    if (last_s) begin
                        done_s = 1'b1;
                        if (in_valid) begin
                            load_s     = 1'b1;
                            state_nx_s = SEND;
                        end else begin
                            state_nx_s = IDLE;
                        end
                    end else begin
                        adv_s = 1'b1;
                    end
                end else begin
                    state_nx_s = SEND;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // FSM state register; reset drops any partially emitted message.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Message capture, chunk index and emitted-message counter.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            msg_r       <= '0;
            idx_r       <= '0;
            msg_count_r <= 16'h0000;
        end else begin
            if (load_s) begin
                msg_r <= PAD_W'(in_data);
                idx_r <= '0;
            end else if (adv_s) begin
                idx_r <= idx_r + IDX_W'(1);
            end
            if (done_s) begin
                msg_count_r <= msg_count_r + 16'd1;
            end
        end
    end

    assign msg_count = msg_count_r;

endmodule
